// File: rtl/block_sprite_pkg.sv
// Shared types for the multi-block sprite engine.
// Motion logic is enabled by defining BLOCK_SPRITE_MOTION_EN.
package block_sprite_pkg;

  localparam int SCREEN_W_DEF = 1280;
  localparam int SCREEN_H_DEF = 720;

  typedef logic [11:0] rgb_t;
  typedef logic signed [11:0] vel_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] w;
    logic [9:0]  h;
    rgb_t        color;
    vel_t        dx;
    vel_t        dy;
  } sprite_t;

endpackage

// File: rtl/sprite_motion.sv
// One-axis bounce update: moves pos by vel and reflects at 0 / LIMIT.
// Used by multi_block_sprite when BLOCK_SPRITE_MOTION_EN is defined.
module sprite_motion
  import block_sprite_pkg::*;
#(
  parameter int POS_W = 11,
  parameter int LIMIT = 1280,
  parameter int VEL_W = 6
) (
  input  logic [POS_W-1:0] pos,
  input  vel_t             vel,
  input  logic [POS_W-1:0] size,
  output logic [POS_W-1:0] pos_nxt,
  output vel_t             vel_nxt
);

  localparam vel_t VEL_MIN = vel_t'(-(2 ** (VEL_W - 1)));
  localparam vel_t VEL_MAX = vel_t'((2 ** (VEL_W - 1)) - 1);
  localparam logic signed [13:0] LIM = 14'(LIMIT);

  logic signed [13:0] np;
  logic signed [13:0] far;
  logic signed [13:0] room;
  vel_t               flip;

  assign np   = 14'($signed({1'b0, pos})) + 14'(vel);
  assign far  = np + 14'($signed({1'b0, size}));
  assign room = LIM - 14'($signed({1'b0, size}));
  // most-negative velocity has no positive twin, so saturate
  assign flip = (vel == VEL_MIN) ? VEL_MAX : -vel;

  always_comb begin
    pos_nxt = np[POS_W-1:0];
    vel_nxt = vel;
    if (np < 14'sd0) begin
      pos_nxt = '0;
      vel_nxt = flip;
    end else if (far > LIM) begin
      pos_nxt = (room < 14'sd0) ? '0 : room[POS_W-1:0];
      vel_nxt = flip;
    end
  end

endmodule

// File: rtl/multi_block_sprite.sv
// Rectangle sprite engine, 2-cycle registered pixel output.
// Define BLOCK_SPRITE_MOTION_EN for per-frame bounce motion.
module multi_block_sprite
  import block_sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int VEL_W       = 6,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             frame_start_in,
  input  logic             wr_en_in,
  input  logic [SEL_W-1:0] wr_sel_in,
  input  logic [10:0]      wr_x_in,
  input  logic [9:0]       wr_y_in,
  input  logic [10:0]      wr_w_in,
  input  logic [9:0]       wr_h_in,
  input  logic [11:0]      wr_color_in,
  input  logic [VEL_W-1:0] wr_dx_in,
  input  logic [VEL_W-1:0] wr_dy_in,
  output logic [11:0]      pixel_out,
  output logic             hit_out,
  output logic [SEL_W-1:0] hit_id_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out
);

  sprite_t spr [NUM_SPRITES];
  sprite_t wr_spr;

  always_comb begin
    wr_spr       = '0;
    wr_spr.x     = wr_x_in;
    wr_spr.y     = wr_y_in;
    wr_spr.w     = wr_w_in;
    wr_spr.h     = wr_h_in;
    wr_spr.color = wr_color_in;
    wr_spr.dx    = vel_t'($signed(wr_dx_in));
    wr_spr.dy    = vel_t'($signed(wr_dy_in));
  end

`ifdef BLOCK_SPRITE_MOTION_EN
  logic [10:0] nx  [NUM_SPRITES];
  logic [9:0]  ny  [NUM_SPRITES];
  vel_t        ndx [NUM_SPRITES];
  vel_t        ndy [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_mot
    sprite_motion #(
      .POS_W(11), .LIMIT(SCREEN_W), .VEL_W(VEL_W)
    ) u_x (
      .pos(spr[g].x), .vel(spr[g].dx), .size(spr[g].w),
      .pos_nxt(nx[g]), .vel_nxt(ndx[g])
    );
    sprite_motion #(
      .POS_W(10), .LIMIT(SCREEN_H), .VEL_W(VEL_W)
    ) u_y (
      .pos(spr[g].y), .vel(spr[g].dy), .size(spr[g].h),
      .pos_nxt(ny[g]), .vel_nxt(ndy[g])
    );
  end
`else
  logic [NUM_SPRITES-1:0] unused_vel;
  logic                   unused_cfg;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sink
    assign unused_vel[g] = ^{spr[g].dx, spr[g].dy};
  end
  assign unused_cfg = ^{frame_start_in, unused_vel,
                        11'(SCREEN_W), 10'(SCREEN_H)};
`endif

  // a write to a sprite overrides its motion on the same edge
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_SPRITES; i++) spr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_en_in && int'(wr_sel_in) == i) begin
          spr[i] <= wr_spr;
`ifdef BLOCK_SPRITE_MOTION_EN
        end else if (frame_start_in && spr[i].w != '0
                     && spr[i].h != '0) begin
          spr[i].x  <= nx[i];
          spr[i].dx <= ndx[i];
          spr[i].y  <= ny[i];
          spr[i].dy <= ndy[i];
`endif
        end
      end
    end
  end

  logic [NUM_SPRITES-1:0] hit_c;

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_c[i] = (spr[i].w != '0) && (spr[i].h != '0)
        && (hcount_in >= spr[i].x)
        && ({1'b0, hcount_in} < {1'b0, spr[i].x} + {1'b0, spr[i].w})
        && (vcount_in >= spr[i].y)
        && ({1'b0, vcount_in} < {1'b0, spr[i].y} + {1'b0, spr[i].h});
    end
  end

  logic [NUM_SPRITES-1:0] hit_q;
  rgb_t                   col_q [NUM_SPRITES];
  logic [10:0]            hc_q;
  logic [9:0]             vc_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= '0;
    end else begin
      hit_q <= hit_c;
      hc_q  <= hcount_in;
      vc_q  <= vcount_in;
      for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= spr[i].color;
    end
  end

  logic             sel_hit;
  logic [SEL_W-1:0] sel_id;
  rgb_t             sel_col;

  // walk downwards so the lowest index wins
  always_comb begin
    sel_hit = 1'b0;
    sel_id  = '0;
    sel_col = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        sel_hit = 1'b1;
        sel_id  = SEL_W'(i);
        sel_col = col_q[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out  <= '0;
      hit_out    <= 1'b0;
      hit_id_out <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      pixel_out  <= sel_col;
      hit_out    <= sel_hit;
      hit_id_out <= sel_id;
      hcount_out <= hc_q;
      vcount_out <= vc_q;
    end
  end

endmodule

// File: tb/tb_multi_block_sprite.sv
// Randomized bench for multi_block_sprite against a sprite-list model.
// Motion is modelled when BLOCK_SPRITE_MOTION_EN is defined.
module tb_multi_block_sprite;

  localparam int N  = 4;
  localparam int VW = 6;
  localparam int SW = 1280;
  localparam int SH = 720;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          frame_start_in;
  logic          wr_en_in;
  logic [1:0]    wr_sel_in;
  logic [10:0]   wr_x_in;
  logic [9:0]    wr_y_in;
  logic [10:0]   wr_w_in;
  logic [9:0]    wr_h_in;
  logic [11:0]   wr_color_in;
  logic [VW-1:0] wr_dx_in;
  logic [VW-1:0] wr_dy_in;
  logic [11:0]   pixel_out;
  logic          hit_out;
  logic [1:0]    hit_id_out;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;

  always #5 clk_in = ~clk_in;

  multi_block_sprite #(
    .NUM_SPRITES(N), .SCREEN_W(SW), .SCREEN_H(SH), .VEL_W(VW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .frame_start_in(frame_start_in),
    .wr_en_in(wr_en_in), .wr_sel_in(wr_sel_in),
    .wr_x_in(wr_x_in), .wr_y_in(wr_y_in),
    .wr_w_in(wr_w_in), .wr_h_in(wr_h_in),
    .wr_color_in(wr_color_in),
    .wr_dx_in(wr_dx_in), .wr_dy_in(wr_dy_in),
    .pixel_out(pixel_out), .hit_out(hit_out),
    .hit_id_out(hit_id_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out)
  );

  int mx [N];
  int my [N];
  int mw [N];
  int mh [N];
  int mc [N];
  int mdx [N];
  int mdy [N];
  logic [63:0] q [$];
  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {28'd0, hit_out, hit_id_out, pixel_out,
            hcount_out, vcount_out};
  endfunction

  function automatic logic [63:0] ref_pix(int hc, int vc);
    for (int i = 0; i < N; i++) begin
      if (mw[i] != 0 && mh[i] != 0 && hc >= mx[i]
          && hc < mx[i] + mw[i] && vc >= my[i]
          && vc < my[i] + mh[i])
        return {28'd0, 1'b1, 2'(i), 12'(mc[i]), 11'(hc), 10'(vc)};
    end
    return {28'd0, 1'b0, 2'd0, 12'd0, 11'(hc), 10'(vc)};
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0;
      mc[i] = 0; mdx[i] = 0; mdy[i] = 0;
    end
  endfunction

`ifdef BLOCK_SPRITE_MOTION_EN
  function automatic int flip(int d);
    return (d == -(1 << (VW - 1))) ? (1 << (VW - 1)) - 1 : -d;
  endfunction

  task automatic move(inout int p, inout int d,
                      input int s, input int lim);
    int np;
    np = p + d;
    if (np < 0) begin
      p = 0; d = flip(d);
    end else if (np + s > lim) begin
      p = (lim - s < 0) ? 0 : lim - s; d = flip(d);
    end else begin
      p = np;
    end
  endtask
`endif

  task automatic wr_set(int sel, int x, int y, int w, int h,
                        int col, int dx, int dy);
    wr_sel_in   = 2'(sel);
    wr_x_in     = 11'(x);
    wr_y_in     = 10'(y);
    wr_w_in     = 11'(w);
    wr_h_in     = 10'(h);
    wr_color_in = 12'(col);
    wr_dx_in    = VW'(dx);
    wr_dy_in    = VW'(dy);
  endtask

  // drive one pixel (plus optional write / frame pulse) for one cycle
  task automatic cyc(int hc, int vc, bit we, bit fs);
    int sel;
    hcount_in      = 11'(hc);
    vcount_in      = 10'(vc);
    wr_en_in       = we;
    frame_start_in = fs;
    q.push_back(ref_pix(int'(hcount_in), int'(vcount_in)));
    sel = int'(wr_sel_in);
`ifdef BLOCK_SPRITE_MOTION_EN
    if (fs) begin
      for (int i = 0; i < N; i++) begin
        if (!(we && sel == i) && mw[i] != 0 && mh[i] != 0) begin
          move(mx[i], mdx[i], mw[i], SW);
          move(my[i], mdy[i], mh[i], SH);
        end
      end
    end
`endif
    if (we && sel < N) begin
      mx[sel]  = int'(wr_x_in);
      my[sel]  = int'(wr_y_in);
      mw[sel]  = int'(wr_w_in);
      mh[sel]  = int'(wr_h_in);
      mc[sel]  = int'(wr_color_in);
      mdx[sel] = int'($signed(wr_dx_in));
      mdy[sel] = int'($signed(wr_dy_in));
    end
    @(posedge clk_in);
    #1;
    if (q.size() == 2) check("pipe", outs(), q.pop_front());
  endtask

  task automatic near(int k);
    int hc;
    int vc;
    hc = mx[k] + int'($urandom_range(0, 5)) - 2;
    if ($urandom_range(0, 1) == 1) hc = mx[k] + mw[k] - 3
                                      + int'($urandom_range(0, 5));
    vc = my[k] + int'($urandom_range(0, 5)) - 2;
    if ($urandom_range(0, 1) == 1) vc = my[k] + mh[k] - 3
                                      + int'($urandom_range(0, 5));
    cyc(hc & 16'h7FF, vc & 16'h3FF, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst_n_in = 1'b0;
    #1 check("rst_async", outs(), 64'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    q.delete();
    clear_model();
  endtask

  int w;
  initial begin
    rst_n_in = 1'b0;
    hcount_in = '0; vcount_in = '0;
    frame_start_in = 1'b0; wr_en_in = 1'b0;
    wr_set(0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    repeat (3) @(posedge clk_in);
    #1 check("rst_init", outs(), 64'd0);
    rst_n_in = 1'b1;

    // single sprite, edges and exact latency
    wr_set(0, 100, 50, 16, 8, 12'hF00, 0, 0);
    cyc(0, 0, 1'b1, 1'b0);
    cyc(100, 50, 1'b0, 1'b0);
    cyc(116, 50, 1'b0, 1'b0);
    check("tp_px", 64'(pixel_out), 64'(12'hF00));
    check("tp_id", 64'({hit_out, hit_id_out}), 64'(3'b100));
    cyc(99, 50, 1'b0, 1'b0);
    check("tp_right", 64'({hit_out, pixel_out}), 64'd0);
    cyc(0, 0, 1'b0, 1'b0);
    check("tp_left", 64'({hit_out, pixel_out}), 64'd0);

    // overlap: lower index wins
    wr_set(0, 190, 190, 20, 20, 12'h0F0, 2, 1);
    cyc(0, 0, 1'b1, 1'b0);
    wr_set(2, 195, 195, 10, 10, 12'h00F, 0, 0);
    cyc(0, 0, 1'b1, 1'b0);
    cyc(200, 200, 1'b0, 1'b0);
    cyc(196, 196, 1'b0, 1'b0);
    check("tp_ovl", 64'({hit_id_out, pixel_out}), 64'({2'd0, 12'h0F0}));
    cyc(0, 0, 1'b0, 1'b0);

    // right-edge bounce, then top-edge bounce and a disabled mover
    wr_set(1, 1270, 100, 16, 4, 12'h111, 5, 0);
    cyc(0, 0, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      cyc(0, 0, 1'b0, 1'b1);
      for (int d = -1; d < 17; d += 3) cyc(mx[1] + d, 100, 1'b0, 1'b0);
      cyc(1264, 101, 1'b0, 1'b0);
      cyc(1259, 101, 1'b0, 1'b0);
      cyc(1279, 101, 1'b0, 1'b0);
    end
    wr_set(3, 10, 2, 4, 4, 12'h333, 0, -4);
    cyc(0, 0, 1'b1, 1'b0);
    wr_set(2, 300, 300, 0, 5, 12'h222, 3, 0);
    cyc(0, 0, 1'b1, 1'b0);
    cyc(0, 0, 1'b0, 1'b1);
    for (int v = 0; v < 7; v++) cyc(11, v, 1'b0, 1'b0);
    cyc(303, 301, 1'b0, 1'b0);

    // write and frame pulse together
    wr_set(1, 500, 400, 8, 8, 12'hABC, 7, 0);
    cyc(0, 0, 1'b1, 1'b1);
    cyc(500, 400, 1'b0, 1'b0);
    cyc(507, 407, 1'b0, 1'b0);
    cyc(508, 400, 1'b0, 1'b0);
    near(0);
    near(0);

    // random writes, frame pulses and pixel probes
    for (int c = 0; c < 3000; c++) begin
      w = int'($urandom_range(0, 99));
      if (w < 12) begin
        wr_set(int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, 1400)),
               int'($urandom_range(0, 760)),
               (w < 2) ? 0 : (w < 3) ? int'($urandom_range(1281, 2047))
                           : int'($urandom_range(1, 64)),
               (w == 11) ? 0 : int'($urandom_range(1, 48)),
               int'($urandom_range(0, 4095)),
               int'($urandom), int'($urandom));
        cyc(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
            1'b1, ($urandom_range(0, 3) == 0));
      end else if (w < 16) begin
        cyc(0, 0, 1'b0, 1'b1);
      end else if (w < 70) begin
        near(int'($urandom_range(0, N - 1)));
      end else begin
        cyc(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
            1'b0, 1'b0);
      end
    end

    // reset mid-scan: everything disabled afterwards
    wr_set(0, 100, 100, 50, 50, 12'hFFF, 1, 1);
    cyc(0, 0, 1'b1, 1'b0);
    cyc(120, 120, 1'b0, 1'b0);
    cyc(121, 121, 1'b0, 1'b0);
    mid_reset();
    for (int c = 0; c < 20; c++) cyc(100 + c, 100 + c, 1'b0, 1'b0);
    cyc(0, 0, 1'b0, 1'b1);
    cyc(120, 120, 1'b0, 1'b0);
    cyc(0, 0, 1'b0, 1'b0);
    cyc(0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_block_sprite.md
# multi_block_sprite

Parametrised rectangle-sprite engine that renders up to NUM_SPRITES solid-color blocks with per-sprite size, color, priority and optional per-frame bouncing motion. Sits in the video pipeline between the timing generator (hcount/vcount) and the pixel mux. Replaces single fixed-size block sprites. Pixel output is registered with a fixed 2-cycle latency; delayed hcount/vcount are provided for downstream alignment.

## Interface

Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..16)
- SCREEN_W, 1280, active width in pixels
- SCREEN_H, 720, active height in lines
- VEL_W, 6, width of signed per-axis velocity

Ports:
- clk_in  input  1  pixel clock; single clock domain
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- frame_start_in  input  1  one-cycle pulse, once per frame (vertical blank)
- wr_en_in  input  1  config write strobe
- wr_sel_in  input  $clog2(NUM_SPRITES)  sprite index written
- wr_x_in  input  11  new x position
- wr_y_in  input  10  new y position
- wr_w_in  input  11  width; 0 disables sprite
- wr_h_in  input  10  height; 0 disables sprite
- wr_color_in  input  12  RGB444 color
- wr_dx_in, wr_dy_in  input  VEL_W each  signed velocity, pixels/frame
- pixel_out  output  12  registered color, 0 when no hit
- hit_out  output  1  registered: some sprite covers pixel
- hit_id_out  output  $clog2(NUM_SPRITES)  index of winning sprite, 0 when no hit
- hcount_out / vcount_out  output  11 / 10  hcount_in/vcount_in delayed 2 cycles

## Operation

- Per-sprite state: x, y, w, h, color, dx, dy. Reset: all fields 0 (every sprite disabled).
- Write: wr_en_in high loads all fields of sprite wr_sel_in at the clock edge. wr_sel_in >= NUM_SPRITES: ignored.
- Hit test per sprite: w!=0, h!=0, x <= hcount < x+w, y <= vcount < y+h; sums computed at 12/11 bits, no wrap.
- Priority: lowest index wins on overlap.
- Motion (on frame_start_in, per axis, 12-bit signed math): nx = x + dx.
  - nx < 0: x <= 0, dx <= -dx.
  - nx + w > SCREEN_W: x <= SCREEN_W - w, dx <= -dx.
  - else x <= nx. Y axis identical with SCREEN_H, h.
  - Disabled sprites (w or h 0) do not move. dx = -2^(VEL_W-1) negates to +2^(VEL_W-1)-1 (saturate).
- Simultaneous wr_en_in and frame_start_in on the same sprite: write wins, no motion that frame for it; other sprites move normally.
- Config written with w > SCREEN_W is accepted; motion clamps x to 0 on first update.

## Timing

- Stage 1 (cycle N+1): per-sprite hit vector and colors registered, hcount/vcount delayed.
- Stage 2 (cycle N+2): priority select, pixel_out/hit_out/hit_id_out valid for inputs sampled at cycle N.
- Config/motion updates affect hit tests from the cycle after the update edge; a write landing mid-line takes effect immediately (tearing allowed; software writes in blanking).
- Reset asserted mid-frame: all outputs and pipeline registers go to 0 asynchronously; release synchronous to clk_in, outputs valid 2 cycles later.

## Configuration

- BLOCK_SPRITE_MOTION_EN defined: per-frame motion/bounce logic as above.
- Undefined: no motion logic synthesised; frame_start_in, wr_dx_in, wr_dy_in ignored; positions change only by writes.

## Structure

- Package block_sprite_pkg: sprite_t struct (x, y, w, h, color, dx, dy), RGB444 color typedef, default SCREEN_W/SCREEN_H constants.
- Sub-module sprite_motion: one-axis bounce update (pos, vel, size, limit) -> (next pos, next vel); instantiated twice per sprite under the macro.

## Test plan

- Reset, write sprite 0 x=100 y=50 w=16 h=8 color 12'hF00; scan (100,50) -> pixel_out 12'hF00, hit_id 0, exactly 2 cycles later; (116,50) and (99,50) -> 0.
- Sprites 0 (12'h0F0) and 2 (12'h00F) overlapping at (200,200) -> pixel_out 12'h0F0, hit_id 0.
- Motion: x=1270 w=16 dx=+5, frame_start -> x=1264, dx=-5; next frame x=1259.
- Motion: y=2 dy=-4 -> y=0, dy=+4; w=0 sprite with dx=3 stays put.
- Write and frame_start same cycle on sprite 1 -> written values held, no move; sprite 0 moves.
- Assert rst_n_in mid-scan -> all outputs 0 immediately; after release, no hits until rewritten.
